// File: rtl/unary_stream_decoder.sv
// Counts the ones in a window of 2^BW valid bits of a unary bitstream and
// presents the total on a valid/ready result port.
module unary_stream_decoder #(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_bit,
    input  logic          in_valid,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW:0]   result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Window closes when the counter reaches 2^BW, i.e. on the 2^BW-th valid bit.
    localparam logic [BW:0] TERMINAL = {1'b1, {BW{1'b0}}};

    state_t        state;
    logic [BW:0]   acc;
    logic [BW:0]   cnt;
    logic [BW:0]   acc_inc;
    logic [BW:0]   cnt_inc;
    logic          last_bit;

    // Both datapaths are BW+1 bits so an all-ones window reaches 2^BW without wrapping.
    assign acc_inc  = acc + {{BW{1'b0}}, in_bit};
    assign cnt_inc  = cnt + {{BW{1'b0}}, 1'b1};
    assign last_bit = in_valid && (cnt_inc == TERMINAL);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ACC;
                    end
                end

                ACC: begin
                    // Invalid cycles stretch the window; start is ignored here.
                    if (in_valid) begin
                        acc <= acc_inc;
                        cnt <= cnt_inc;
                        if (last_bit) begin
                            result    <= acc_inc;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    // Result is frozen until accepted; a same-cycle start chains windows.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            acc   <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= ACC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Directed self-checking bench for unary_stream_decoder with BW=4 (16-bit window).
module tb_unary_stream_decoder;

    localparam int BW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_bit;
    logic          in_valid;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [BW:0]   result;

    int checks = 0;
    int errors = 0;

    unary_stream_decoder #(.BW(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic open_window();
        start = 1'b1;
        step();
        start = 1'b0;
        check("open_busy", 32'(busy), 32'd1);
    endtask

    // Feeds 16 valid bits (LSB first) and checks the window closes exactly on the 16th.
    task automatic feed_window(input string tag, input logic [15:0] pat);
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_bit = pat[i];
            step();
            if (i == 14) check({tag, "_ov_before_last"}, 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        check({tag, "_ov"}, 32'(out_valid), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("accept_ov", 32'(out_valid), 32'd0);
        check("accept_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int busy_cycles;

        rst_n     = 1'b0;
        start     = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ov", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        #20;
        rst_n = 1'b1;
        step();

        // IDLE ignores bits without a start.
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("idle_ignore_busy", 32'(busy), 32'd0);
        check("idle_ignore_ov", 32'(out_valid), 32'd0);
        in_valid = 1'b0;

        // All ones: 16 with no wrap.
        open_window();
        feed_window("ones", 16'hFFFF);
        check("ones_result", 32'(result), 32'd16);
        accept();

        // Alternating 1,0: 8.
        open_window();
        feed_window("alt", 16'h5555);
        check("alt_result", 32'(result), 32'd8);
        accept();

        // All zeros: 0.
        open_window();
        feed_window("zeros", 16'h0000);
        check("zeros_result", 32'(result), 32'd0);
        accept();

        // Every third cycle invalid: 24 busy cycles for 16 valid ones.
        open_window();
        busy_cycles = 0;
        for (int c = 0; c < 24; c++) begin
            in_valid = (c % 3 != 0);
            in_bit   = in_valid;
            if (busy) busy_cycles++;
            step();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        check("gap_busy_cycles", 32'(busy_cycles), 32'd24);
        check("gap_ov", 32'(out_valid), 32'd1);
        check("gap_result", 32'(result), 32'd16);

        // Stall in HOLD: bits and start pulses must not disturb the result.
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_bit = c[0];
            start  = ~c[0];
            step();
            check("hold_ov", 32'(out_valid), 32'd1);
            check("hold_busy", 32'(busy), 32'd0);
            check("hold_result", 32'(result), 32'd16);
        end
        start    = 1'b0;
        in_valid = 1'b0;

        // Accept and restart in the same cycle: next window counts from zero.
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_ov", 32'(out_valid), 32'd0);
        feed_window("b2b", 16'h001F);
        check("b2b_result", 32'(result), 32'd5);
        accept();

        // Reset mid-window after 9 ones clears everything asynchronously.
        open_window();
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int i = 0; i < 9; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ov", 32'(out_valid), 32'd0);
        check("arst_result", 32'(result), 32'd0);
        step();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_ov", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        in_bit   = 1'b0;

        open_window();
        feed_window("three", 16'h0007);
        check("three_result", 32'(result), 32'd3);
        accept();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
